// File: rtl/gf2_inv_pkg.sv
// Shared types and constants for the GF(2) NxN matrix inverter.
// Holds the FSM state enum and the identity-matrix generator.
package gf2_inv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PIVOT,
    ELIM
  } state_t;

  localparam int MAX_N = 8;

  // Row-major packing: row 0 and column 0 sit in the most significant positions.
  function automatic logic [MAX_N*MAX_N-1:0] identity_matrix(input int n);
    logic [MAX_N*MAX_N-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) m[(n-1-i)*(n+1)] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gf2_pivot_finder.sv
// Combinational priority search for the lowest row >= start_row whose bit is set
// in the current pivot column of the working matrix.
module gf2_pivot_finder #(
  parameter int N = 4
) (
  input  logic [N-1:0]         col_bits,
  input  logic [$clog2(N)-1:0] start_row,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);

  localparam int CW = $clog2(N);

  // Scanning downwards lets the lowest qualifying row overwrite any higher one.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int r = N - 1; r >= 0; r--) begin
      if (col_bits[r] && (r >= int'(start_row))) begin
        found = 1'b1;
        index = CW'(r);
      end
    end
  end

endmodule

// File: rtl/gf2_nxn_matrix_inverter.sv
// Iterative Gauss-Jordan GF(2) inverter on an augmented [A | I] register array.
// Define GF2_INV_RANK_EN to skip missing pivots and report the matrix rank.
module gf2_nxn_matrix_inverter
  import gf2_inv_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     str,
  input  logic [N*N-1:0]           input_matrix,
  output logic [N*N-1:0]           output_matrix,
  output logic                     bsy,
  output logic                     fin,
`ifdef GF2_INV_RANK_EN
  output logic [$clog2(N+1)-1:0]   rank,
`endif
  output logic                     sing
);

  localparam int CW = $clog2(N);
  localparam logic [MAX_N*MAX_N-1:0] IDENT_FULL = identity_matrix(N);

  state_t          state;
  logic [CW-1:0]   col;
  logic [N-1:0]    a [N];
  logic [N-1:0]    b [N];

  logic [CW-1:0]   start_row;
  logic [CW-1:0]   col_idx;
  logic [CW-1:0]   pivot_row;
  logic            pivot_found;
  logic            last_col;
  logic [N-1:0]    col_bits;
  logic [N-1:0]    a_elim [N];
  logic [N-1:0]    b_elim [N];
  logic [N*N-1:0]  b_packed;

`ifdef GF2_INV_RANK_EN
  localparam int RW = $clog2(N+1);
  logic [RW-1:0]   piv_cnt;
  logic [RW-1:0]   piv_next;
  logic            rank_short;

  // Pivot rows advance only when a pivot is found, so they trail col on skipped columns.
  assign start_row  = piv_cnt[CW-1:0];
  assign piv_next   = piv_cnt + 1'b1;
  assign rank_short = (piv_next != RW'(N));
`else
  assign start_row = col;
`endif

  assign last_col = (col == CW'(N - 1));

  // Column extraction and the parallel row-clear that ELIM commits in one edge.
  always_comb begin
    col_idx  = CW'(N - 1) - col;
    col_bits = '0;
    b_packed = '0;
    for (int r = 0; r < N; r++) begin
      col_bits[r] = a[r][col_idx];
      a_elim[r]   = a[r];
      b_elim[r]   = b[r];
      if ((r != int'(start_row)) && a[r][col_idx]) begin
        a_elim[r] = a[r] ^ a[start_row];
        b_elim[r] = b[r] ^ b[start_row];
      end
    end
    for (int i = 0; i < N; i++) begin
      b_packed[(N-1-i)*N +: N] = b_elim[i];
    end
  end

  gf2_pivot_finder #(
    .N(N)
  ) u_pivot_finder (
    .col_bits (col_bits),
    .start_row(start_row),
    .found    (pivot_found),
    .index    (pivot_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      col           <= '0;
      output_matrix <= '0;
      bsy           <= 1'b0;
      fin           <= 1'b0;
      sing          <= 1'b0;
      for (int r = 0; r < N; r++) begin
        a[r] <= '0;
        b[r] <= '0;
      end
`ifdef GF2_INV_RANK_EN
      piv_cnt <= '0;
      rank    <= '0;
`endif
    end else begin
      fin <= 1'b0;
      case (state)
        IDLE: begin
          if (str) begin
            for (int r = 0; r < N; r++) begin
              a[r] <= input_matrix[(N-1-r)*N +: N];
              b[r] <= IDENT_FULL[(N-1-r)*N +: N];
            end
            col   <= '0;
            bsy   <= 1'b1;
            sing  <= 1'b0;
`ifdef GF2_INV_RANK_EN
            piv_cnt <= '0;
`endif
            state <= PIVOT;
          end
        end

        PIVOT: begin
          if (pivot_found) begin
            a[start_row] <= a[pivot_row];
            a[pivot_row] <= a[start_row];
            b[start_row] <= b[pivot_row];
            b[pivot_row] <= b[start_row];
            state        <= ELIM;
          end else begin
`ifdef GF2_INV_RANK_EN
            if (last_col) begin
              output_matrix <= '0;
              rank          <= piv_cnt;
              sing          <= 1'b1;
              fin           <= 1'b1;
              bsy           <= 1'b0;
              state         <= IDLE;
            end else begin
              col <= col + 1'b1;
            end
`else
            output_matrix <= '0;
            sing          <= 1'b1;
            fin           <= 1'b1;
            bsy           <= 1'b0;
            state         <= IDLE;
`endif
          end
        end

        ELIM: begin
          for (int r = 0; r < N; r++) begin
            a[r] <= a_elim[r];
            b[r] <= b_elim[r];
          end
`ifdef GF2_INV_RANK_EN
          piv_cnt <= piv_next;
`endif
          if (last_col) begin
`ifdef GF2_INV_RANK_EN
            output_matrix <= rank_short ? '0 : b_packed;
            sing          <= rank_short;
            rank          <= piv_next;
`else
            output_matrix <= b_packed;
`endif
            fin   <= 1'b1;
            bsy   <= 1'b0;
            state <= IDLE;
          end else begin
            col   <= col + 1'b1;
            state <= PIVOT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_nxn_matrix_inverter.sv
// Self-checking bench for gf2_nxn_matrix_inverter (N=4 and N=8 instances).
// Works with or without GF2_INV_RANK_EN defined.
module tb_gf2_nxn_matrix_inverter;

  typedef struct {
    logic [63:0] out;
    logic        sing;
    int          rank;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        str4, str8;
  logic [15:0] in4, out4;
  logic [63:0] in8, out8;
  logic        bsy4, fin4, sing4, bsy8, fin8, sing8;
  int          rk4_i, rk8_i;
`ifdef GF2_INV_RANK_EN
  logic [2:0]  rank4;
  logic [3:0]  rank8;
  assign rk4_i = int'(rank4);
  assign rk8_i = int'(rank8);
`else
  assign rk4_i = 0;
  assign rk8_i = 0;
`endif

  gf2_nxn_matrix_inverter #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .str(str4), .input_matrix(in4), .output_matrix(out4),
    .bsy(bsy4), .fin(fin4),
`ifdef GF2_INV_RANK_EN
    .rank(rank4),
`endif
    .sing(sing4)
  );

  gf2_nxn_matrix_inverter #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .str(str8), .input_matrix(in8), .output_matrix(out8),
    .bsy(bsy8), .fin(fin8),
`ifdef GF2_INV_RANK_EN
    .rank(rank8),
`endif
    .sing(sing8)
  );

  int checks = 0;
  int errors = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        cur [2];
  logic        active [2];
  int          cnt [2];
  logic [63:0] last_out [2];
  logic        last_sing [2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (matrix algebra, not the FSM) ----------------
  function automatic logic elem(input logic [63:0] m, input int n, input int r, input int c);
    return m[(n-1-r)*n + (n-1-c)];
  endfunction

  function automatic logic [63:0] ident(input int n);
    logic [63:0] m = '0;
    for (int i = 0; i < n; i++) m[(n-1-i)*n + (n-1-i)] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] matMul(input logic [63:0] x, input logic [63:0] y, input int n);
    logic [63:0] p = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        logic s = 1'b0;
        for (int k = 0; k < n; k++) s ^= elem(x, n, i, k) & elem(y, n, k, j);
        p[(n-1-i)*n + (n-1-j)] = s;
      end
    return p;
  endfunction

  function automatic logic [63:0] gjInverse(input logic [63:0] m, input int n);
    logic [7:0] la [8];
    logic [7:0] lb [8];
    logic [7:0] t;
    logic [63:0] res = '0;
    for (int i = 0; i < 8; i++) begin
      la[i] = '0; lb[i] = '0;
      for (int j = 0; j < n; j++) la[i][j] = (i < n) ? elem(m, n, i, j) : 1'b0;
      if (i < n) lb[i][i] = 1'b1;
    end
    for (int c = 0; c < n; c++) begin
      int p = -1;
      for (int r = n - 1; r >= c; r--) if (la[r][c]) p = r;
      if (p >= 0) begin
        t = la[c]; la[c] = la[p]; la[p] = t;
        t = lb[c]; lb[c] = lb[p]; lb[p] = t;
        for (int k = 0; k < n; k++)
          if (k != c && la[k][c]) begin la[k] ^= la[c]; lb[k] ^= lb[c]; end
      end
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) res[(n-1-i)*n + (n-1-j)] = lb[i][j];
    return res;
  endfunction

  // Column-prefix ranks decide pivot misses; latency follows from them.
  function automatic exp_t model(input logic [63:0] m, input int n);
    exp_t e;
    logic [7:0] basis [8];
    logic [7:0] v;
    int rk = 0, miss = -1, lat = 0, prev;
    for (int i = 0; i < 8; i++) basis[i] = '0;
    for (int c = 0; c < n; c++) begin
      v = '0;
      for (int r = 0; r < n; r++) v[r] = elem(m, n, r, c);
      prev = rk;
      for (int bt = 7; bt >= 0; bt--) begin
        if (v[bt]) begin
          if (basis[bt] != 0) v ^= basis[bt];
          else begin basis[bt] = v; rk++; break; end
        end
      end
      if (rk > prev) lat += 2;
      else begin lat += 1; if (miss < 0) miss = c; end
    end
`ifndef GF2_INV_RANK_EN
    if (miss >= 0) lat = 2 * miss + 1;
`endif
    e.rank = rk;
    e.sing = (rk != n);
    e.lat  = lat;
    e.out  = e.sing ? 64'd0 : gjInverse(m, n);
    return e;
  endfunction

  // ---------------- per-cycle compare ----------------
  task automatic compareInst(input int i, input logic s, input logic b, input logic f,
                             input logic sg, input logic [63:0] o, input int rk);
    exp_t e;
    if (active[i]) begin
      cnt[i]++;
      if (cnt[i] < cur[i].lat) begin
        checkOutput($sformatf("bsy_run%0d", i), 64'(b), 64'd1);
        checkOutput($sformatf("fin_run%0d", i), 64'(f), 64'd0);
        checkOutput($sformatf("sing_run%0d", i), 64'(sg), 64'd0);
        checkOutput($sformatf("out_hold%0d", i), o, last_out[i]);
      end else begin
        checkOutput($sformatf("fin%0d", i), 64'(f), 64'd1);
        checkOutput($sformatf("bsy_done%0d", i), 64'(b), 64'd0);
        checkOutput($sformatf("sing%0d", i), 64'(sg), 64'(cur[i].sing));
        checkOutput($sformatf("result%0d", i), o, cur[i].out);
`ifdef GF2_INV_RANK_EN
        checkOutput($sformatf("rank%0d", i), 64'(rk), 64'(cur[i].rank));
`endif
        last_out[i]  = cur[i].out;
        last_sing[i] = cur[i].sing;
        active[i]    = 1'b0;
      end
    end else begin
      checkOutput($sformatf("bsy_idle%0d", i), 64'(b), 64'd0);
      checkOutput($sformatf("fin_idle%0d", i), 64'(f), 64'd0);
      checkOutput($sformatf("sing_idle%0d", i), 64'(sg), 64'(last_sing[i]));
      checkOutput($sformatf("out_idle%0d", i), o, last_out[i]);
    end
    if (s) begin
      if (i == 0 && q0.size() > 0) e = q0.pop_front();
      else if (i == 1 && q1.size() > 0) e = q1.pop_front();
      else begin e.out = '0; e.sing = 1'b0; e.rank = 0; e.lat = 0; end
      cur[i]       = e;
      active[i]    = 1'b1;
      cnt[i]       = -1;
      last_sing[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_out4", {48'd0, out4}, 64'd0);
      checkOutput("rst_flags4", {61'd0, bsy4, fin4, sing4}, 64'd0);
      checkOutput("rst_out8", out8, 64'd0);
      checkOutput("rst_flags8", {61'd0, bsy8, fin8, sing8}, 64'd0);
      for (int i = 0; i < 2; i++) begin
        active[i] = 1'b0; last_out[i] = '0; last_sing[i] = 1'b0;
      end
      q0.delete();
      q1.delete();
    end else begin
      compareInst(0, str4, bsy4, fin4, sing4, {48'd0, out4}, rk4_i);
      compareInst(1, str8, bsy8, fin8, sing8, out8, rk8_i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input int i, input logic [63:0] m, input logic immediate);
    exp_t e;
    if (!immediate) begin @(posedge clk); #2; end
    if (i == 0) begin
      e = model(m, 4); q0.push_back(e); in4 = m[15:0]; str4 = 1'b1;
    end else begin
      e = model(m, 8); q1.push_back(e); in8 = m; str8 = 1'b1;
    end
    @(posedge clk); #2;
    str4 = 1'b0;
    str8 = 1'b0;
  endtask

  task automatic waitIdle(input int i);
    int guard = 0;
    while (active[i] && guard < 100) begin @(posedge clk); guard++; end
    if (guard >= 100) begin
      checks++; errors++;
      $display("[TB] FAIL timeout%0d: run still active after %0d cycles, expected completion", i, guard);
    end
  endtask

  task automatic waitFin4();
    int guard = 0;
    do begin @(posedge clk); #2; guard++; end while (!fin4 && guard < 100);
    if (!fin4) begin
      checks++; errors++;
      $display("[TB] FAIL fin_wait: fin=%b after %0d cycles, expected 1", fin4, guard);
    end
  endtask

  initial begin
    exp_t e;
    logic [63:0] rnd;
    rst = 1'b1; str4 = 1'b0; str8 = 1'b0; in4 = '0; in8 = '0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; last_out[i] = '0; last_sing[i] = 1'b0; cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Hand-computed pins on the model itself
    e = model(64'hCA31, 4);
    checkOutput("model_ca31_out", e.out, 64'h7F31);
    checkOutput("model_ca31_lat", 64'(e.lat), 64'd8);
    e = model(64'h4821, 4);
    checkOutput("model_4821_out", e.out, 64'h4821);
    e = model(64'hCC31, 4);
    checkOutput("model_cc31_sing", 64'(e.sing), 64'd1);
`ifdef GF2_INV_RANK_EN
    checkOutput("model_cc31_rank", 64'(e.rank), 64'd3);
    checkOutput("model_cc31_lat", 64'(e.lat), 64'd7);
`else
    checkOutput("model_cc31_lat", 64'(e.lat), 64'd3);
`endif

    $display("[TB] N=4 invertible, then back-to-back identity");
    applyStimulus(0, 64'hCA31, 1'b0);
    waitFin4();
    applyStimulus(0, 64'h8421, 1'b1);
    waitIdle(0);
    applyStimulus(0, 64'h4821, 1'b0);
    waitIdle(0);
    applyStimulus(0, 64'hCC31, 1'b0);
    waitIdle(0);
    applyStimulus(0, 64'hCA31, 1'b0);
    waitIdle(0);

    $display("[TB] reset mid-elimination");
    applyStimulus(0, 64'hCA31, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out", {48'd0, out4}, 64'd0);
    checkOutput("async_rst_flags", {61'd0, bsy4, fin4, sing4}, 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (12) @(posedge clk);
    applyStimulus(0, 64'hCA31, 1'b0);
    waitIdle(0);

    $display("[TB] N=8 identity and random invertible");
    applyStimulus(1, ident(8), 1'b0);
    waitIdle(1);
    checkOutput("prod8_ident", matMul(in8, out8, 8), ident(8));
    rnd = {$urandom, $urandom};
    for (int t = 0; t < 100; t++) begin
      e = model(rnd, 8);
      if (!e.sing) break;
      rnd = {$urandom, $urandom};
    end
    applyStimulus(1, rnd, 1'b0);
    waitIdle(1);
    checkOutput("prod8_rand", matMul(in8, out8, 8), ident(8));
    checkOutput("prod8_rand_rev", matMul(out8, in8, 8), ident(8));

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
